// File: rtl/present_player_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : present_player_pipe
//  Description : PRESENT-style bit permutation (pLayer) with a selectable
//                forward/inverse mode per word, followed by a valid/ready
//                pipeline of STAGES register stages and an output handshake
//                counter.
//  Revision    : 1.0  initial release
// ============================================================================
module present_player_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_inverse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      count
);

  // Forward and inverse permutations of the incoming word.
  logic [WIDTH-1:0] w_fwd;
  logic [WIDTH-1:0] w_inv;
  logic [WIDTH-1:0] w_perm;

  // Per-stage state: one valid flag plus one data word per stage.
  logic [STAGES-1:0]            r_valid;
  logic [STAGES-1:0][WIDTH-1:0] r_data;

  // Per-stage load enables and the value each stage would capture.
  logic [STAGES-1:0]            w_load;
  logic [STAGES-1:0]            w_in_valid;
  logic [STAGES-1:0][WIDTH-1:0] w_in_data;
  logic                         w_down;
  logic                         w_accept;
  logic                         w_out_hs;

  // Bit i moves to position P(i); the top bit is a fixed point. Every
  // index is an elaboration-time constant, so this is pure wiring.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_perm
    localparam int P = (gi == WIDTH - 1) ? (WIDTH - 1)
                                         : ((gi * (WIDTH / 4)) % (WIDTH - 1));
    assign w_fwd[P]  = in_data[gi];
    assign w_inv[gi] = in_data[P];
  end

  assign w_perm = in_inverse ? w_inv : w_fwd;

  // Stage load enables, walked from the output back towards the input:
  // a stage may load when it is empty or when its word leaves this cycle.
  always_comb begin
    w_load = '0;
    w_down = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_load[k] = ~r_valid[k] | (r_valid[k] & w_down);
      w_down    = w_load[k];
    end
  end

  // Input handshake; blocked during clear and while reset is asserted.
  assign in_ready = reset_n & ~clear & w_load[0];
  assign w_accept = in_valid & in_ready;

  // Output handshake taken from the last stage.
  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign w_out_hs  = r_valid[STAGES-1] & out_ready;

  // What each stage captures: stage 1 takes the permuted input word,
  // later stages take the previous stage unchanged.
  always_comb begin
    w_in_valid    = '0;
    w_in_data     = '0;
    w_in_valid[0] = w_accept;
    w_in_data[0]  = w_perm;
    for (int k = 1; k < STAGES; k++) begin
      w_in_valid[k] = r_valid[k-1];
      w_in_data[k]  = r_data[k-1];
    end
  end

  // Stage registers: flush on clear, otherwise load or hold per stage.
  // Data is only written when a valid word arrives, so a stalled word and
  // an empty stage both keep their contents untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else if (clear) begin
      r_valid <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= w_in_valid[k];
          if (w_in_valid[k]) begin
            r_data[k] <= w_in_data[k];
          end
        end
      end
    end
  end

  // Completed output handshakes, wrapping at 16 bits; clear wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 16'h0000;
    end else if (clear) begin
      count <= 16'h0000;
    end else if (w_out_hs) begin
      count <= count + 16'h0001;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_present_player_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_present_player_pipe
//  Description : Self-checking bench. A single-stage instance runs a vector
//                table; a three-stage instance is tracked by a queue-based
//                reference model under directed and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_present_player_pipe;

  localparam int W = 64;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // Single-stage instance signals
  logic          a_clear = 1'b0;
  logic          a_in_valid, a_in_ready, a_in_inverse;
  logic [W-1:0]  a_in_data;
  logic          a_out_valid, a_out_ready;
  logic [W-1:0]  a_out_data;
  logic [15:0]   a_count;

  // Three-stage instance signals
  logic          b_clear;
  logic          b_in_valid, b_in_ready, b_in_inverse;
  logic [W-1:0]  b_in_data;
  logic          b_out_valid, b_out_ready;
  logic [W-1:0]  b_out_data;
  logic [15:0]   b_count;

  present_player_pipe #(.WIDTH(W), .STAGES(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .clear(a_clear),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_inverse(a_in_inverse), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .count(a_count)
  );

  present_player_pipe #(.WIDTH(W), .STAGES(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .clear(b_clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_inverse(b_in_inverse), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .count(b_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state for the three-stage instance.
  logic [W-1:0] q[$];
  logic [15:0]  m_count = 16'h0000;

  // Forward: P is multiplication by W/4 mod W-1, whose inverse is
  // multiplication by 4, so result bit j comes from input bit 4j mod 63.
  // Inverse: result bit i comes from input bit P(i).
  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic inv);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < W - 1; j++) begin
      if (inv) r[j] = x[(j * (W / 4)) % (W - 1)];
      else     r[j] = x[(4 * j) % (W - 1)];
    end
    r[W-1] = x[W-1];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Scoreboard: runs mid-cycle after the driver has set this cycle's inputs,
  // so the sampled handshakes are those that fire on the next rising edge.
  always begin
    @(negedge clock);
    #2;
    if (reset_n) begin
      chk("count_track", {48'b0, b_count}, {48'b0, m_count});
      if (b_out_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_unexpected: got %h with no word pending", b_out_data);
        end else begin
          chk("out_data_order", b_out_data, q[0]);
        end
      end
      if (b_clear) begin
        q.delete();
        m_count = 16'h0000;
      end else begin
        if (b_out_valid && b_out_ready && q.size() > 0) begin
          void'(q.pop_front());
          m_count = m_count + 16'h0001;
        end
        if (b_in_valid && b_in_ready) q.push_back(model(b_in_data, b_in_inverse));
      end
    end
  end

  // Reset discards every in-flight word and the count.
  always @(negedge reset_n) begin
    q.delete();
    m_count = 16'h0000;
  end

  // Present words with out_ready low until the pipe refuses one; that last
  // word stays presented with in_valid high.
  task automatic fill_stalled();
    logic full;
    full = 1'b0;
    b_out_ready = 1'b0;
    for (int n = 0; n < 8 && !full; n++) begin
      @(negedge clock);
      b_in_valid   = 1'b1;
      b_in_data    = rnd64();
      b_in_inverse = 1'($urandom_range(0, 1));
      #1;
      if (!b_in_ready) full = 1'b1;
    end
    chk("fill_stalled_full", {63'b0, full}, 64'd1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clock);
      #3;
      if (q.size() == 0 && !b_out_valid) done = 1'b1;
    end
    chk("drain_complete", {63'b0, done}, 64'd1);
  endtask

  task automatic stream(input int n_words);
    b_out_ready = 1'b1;
    for (int n = 0; n < n_words; n++) begin
      @(negedge clock);
      b_in_valid   = 1'b1;
      b_in_data    = rnd64();
      b_in_inverse = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    b_in_valid = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic         inv;
    logic [W-1:0] exp;
  } vec_t;

  localparam int NV = 10;
  vec_t vt[NV];

  initial begin
    logic [W-1:0] saved;
    logic         last_acc;

    a_in_valid = 1'b0; a_in_data = '0; a_in_inverse = 1'b0; a_out_ready = 1'b1;
    b_clear = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_inverse = 1'b0;
    b_out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    chk("rst_out_valid", {63'b0, b_out_valid}, 64'd0);
    chk("rst_out_data", b_out_data, 64'd0);
    chk("rst_count", {48'b0, b_count}, 64'd0);
    chk("rst_in_ready", {63'b0, b_in_ready}, 64'd0);
    chk("rst_in_ready_s1", {63'b0, a_in_ready}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'b0, b_in_ready}, 64'd1);
    chk("post_rst_in_ready_s1", {63'b0, a_in_ready}, 64'd1);

    // Vector table on the single-stage instance, back to back, mixed modes
    vt[0] = '{64'h0000000000000002, 1'b0, 64'h0000000000010000};
    vt[1] = '{64'h0000000000000010, 1'b0, 64'h0000000000000002};
    vt[2] = '{64'h8000000000000000, 1'b0, 64'h8000000000000000};
    vt[3] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF};
    vt[4] = '{64'h0000000000010000, 1'b1, 64'h0000000000000002};
    vt[5] = '{64'h45EF82118F2845A3, 1'b0, model(64'h45EF82118F2845A3, 1'b0)};
    vt[6] = '{model(64'h45EF82118F2845A3, 1'b0), 1'b1, 64'h45EF82118F2845A3};
    for (int i = 7; i < NV; i++) begin
      vt[i].din = rnd64();
      vt[i].inv = 1'(i % 2);
      vt[i].exp = model(vt[i].din, vt[i].inv);
    end
    for (int i = 0; i <= NV; i++) begin
      @(negedge clock);
      if (i == 0) begin
        chk("s1_idle_valid", {63'b0, a_out_valid}, 64'd0);
      end else begin
        chk("s1_out_valid", {63'b0, a_out_valid}, 64'd1);
        chk("s1_out_data", a_out_data, vt[i-1].exp);
      end
      if (i < NV) begin
        a_in_valid = 1'b1; a_in_data = vt[i].din; a_in_inverse = vt[i].inv;
      end else begin
        a_in_valid = 1'b0;
      end
    end
    @(negedge clock);
    chk("s1_valid_after", {63'b0, a_out_valid}, 64'd0);
    chk("s1_count", {48'b0, a_count}, NV);

    // Latency and throughput on the three-stage instance
    b_out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clock);
      if (n == 1 || n == 2) chk("lat_not_yet", {63'b0, b_out_valid}, 64'd0);
      if (n >= 3 && n <= 12) chk("lat_stream_valid", {63'b0, b_out_valid}, 64'd1);
      if (n < 10) begin
        b_in_valid = 1'b1; b_in_data = rnd64(); b_in_inverse = 1'($urandom_range(0, 1));
        #1;
        chk("lat_in_ready", {63'b0, b_in_ready}, 64'd1);
      end else begin
        b_in_valid = 1'b0;
      end
    end
    chk("lat_count10", {48'b0, b_count}, 64'd10);

    // Backpressure with a full pipe
    fill_stalled();
    @(negedge clock);
    saved = b_out_data;
    chk("bp_valid", {63'b0, b_out_valid}, 64'd1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clock);
      #1;
      chk("bp_in_ready", {63'b0, b_in_ready}, 64'd0);
      chk("bp_out_stable", b_out_data, saved);
    end
    @(negedge clock);
    b_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'b0, b_in_ready}, 64'd1);
    drain();

    // Random traffic, upstream holds words while stalled
    last_acc = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      b_out_ready = ($urandom_range(0, 3) != 0);
      if (!(b_in_valid && !last_acc)) begin
        b_in_valid   = 1'($urandom_range(0, 1));
        b_in_data    = rnd64();
        b_in_inverse = 1'($urandom_range(0, 1));
      end
      #1;
      last_acc = b_in_valid & b_in_ready;
    end
    drain();

    // Count wrap
    @(negedge clock); b_clear = 1'b1;
    @(negedge clock); b_clear = 1'b0;
    stream(65535);
    drain();
    chk("count_ffff", {48'b0, b_count}, 64'h000000000000FFFF);
    stream(1);
    drain();
    chk("count_wrap", {48'b0, b_count}, 64'd0);

    // Clear with a full pipe and a word offered
    stream(3);
    drain();
    fill_stalled();
    @(negedge clock);
    b_clear = 1'b1; b_in_valid = 1'b1; b_out_ready = 1'b1;
    #1;
    chk("clr_in_ready", {63'b0, b_in_ready}, 64'd0);
    @(negedge clock);
    b_clear = 1'b0; b_in_valid = 1'b0;
    chk("clr_valid", {63'b0, b_out_valid}, 64'd0);
    chk("clr_count", {48'b0, b_count}, 64'd0);
    repeat (3) @(negedge clock);
    chk("clr_not_accepted", {63'b0, b_out_valid}, 64'd0);
    chk("clr_count_hold", {48'b0, b_count}, 64'd0);

    // Asynchronous reset pulse with a full pipe
    stream(2);
    drain();
    fill_stalled();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {63'b0, b_out_valid}, 64'd0);
    chk("arst_data", b_out_data, 64'd0);
    chk("arst_count", {48'b0, b_count}, 64'd0);
    chk("arst_in_ready", {63'b0, b_in_ready}, 64'd0);
    b_in_valid = 1'b0;
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    chk("arst_after_ready", {63'b0, b_in_ready}, 64'd1);
    chk("arst_after_valid", {63'b0, b_out_valid}, 64'd0);
    chk("arst_after_count", {48'b0, b_count}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/present_player_pipe.md
PRESENT_PLAYER_PIPE -- requirements
Module: present_player_pipe

Interface
REQ-001 Parameter WIDTH, default 64, permuted state width; SHALL be a multiple of 4 and >= 8.
REQ-002 Parameter STAGES, default 1, pipeline depth in register stages; SHALL be in the range 1..4.
REQ-003 Port clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port clear  input  1  synchronous flush of the pipeline and the counter.
REQ-006 Port in_valid  input  1  upstream word present.
REQ-007 Port in_ready  output  1  block accepts a word this cycle.
REQ-008 Port in_data  input  WIDTH  state word to permute.
REQ-009 Port in_inverse  input  1  per-word mode: 0 = forward pLayer, 1 = inverse pLayer.
REQ-010 Port out_valid  output  1  permuted word present.
REQ-011 Port out_ready  input  1  downstream accepts a word.
REQ-012 Port out_data  output  WIDTH  permuted state word.
REQ-013 Port count  output  16  number of completed output handshakes.

Function
REQ-014 Define P(i) = (i*WIDTH/4) mod (WIDTH-1) for i < WIDTH-1, and P(WIDTH-1) = WIDTH-1.
REQ-015 Forward mode SHALL set result bit P(i) = input bit i for every i.
REQ-016 Inverse mode SHALL set result bit i = input bit P(i) for every i, so that inverse(forward(x)) = x.
REQ-017 Input accept SHALL occur on a cycle with in_valid=1 and in_ready=1; the permutation SHALL be applied on entry to stage 1, and in_inverse SHALL be sampled with the same word.
REQ-018 Each stage SHALL hold one valid bit plus WIDTH data bits. Stages 2..STAGES SHALL be pure delay.
REQ-019 Stage k SHALL load when it is empty or when its contents advance in the same cycle; otherwise it SHALL hold.
REQ-020 out_valid and out_data SHALL be driven from stage STAGES. The last stage advances on out_valid=1 and out_ready=1.
REQ-021 Latency SHALL be exactly STAGES cycles from accept to out_valid, with no stall.
REQ-022 Throughput SHALL be one word per cycle while out_ready=1.
REQ-023 When out_valid=1 and out_ready=0, out_data SHALL remain stable and no word SHALL be lost or duplicated.
REQ-024 in_ready SHALL be combinational: 1 if stage 1 is empty or stage 1 advances this cycle, and forced 0 when clear=1 or reset_n=0.
REQ-025 Upstream SHALL hold in_data and in_inverse stable while in_valid=1 and in_ready=0.
REQ-026 A simultaneous accept into stage 1 and advance out of stage STAGES SHALL both take effect; count SHALL increment.
REQ-027 count SHALL increment by 1 per output handshake and wrap from 0xFFFF to 0x0000.
REQ-028 clear=1 SHALL, at the next edge, zero all valid bits and count.
REQ-029 With clear=1, no input SHALL be accepted, regardless of in_valid.
REQ-030 With clear=1, an output handshake in that cycle SHALL NOT be counted.
REQ-031 The sole state SHALL be stage registers and count; there is no FSM beyond per-stage valid bits.

Reset
REQ-032 reset_n=0 SHALL asynchronously clear all valid bits, all stage data, and count to 0. This gives out_valid=0, out_data=0, count=0x0000 and in_ready=0.
REQ-033 After reset_n deasserts, in_ready SHALL be 1 in the first cycle in which clear=0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight words without producing an output handshake.

Verification
REQ-035 WIDTH=64, STAGES=1, forward, out_ready=1. Inputs 0x0000000000000002 -> 0x0000000000010000; 0x0000000000000010 -> 0x0000000000000002; 0x8000000000000000 -> 0x8000000000000000; 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFF; each appears 1 cycle after accept.
REQ-036 Inverse mode: 0x0000000000010000 -> 0x0000000000000002. Also a forward then inverse round-trip of 0x45EF82118F2845A3 -> 0x45EF82118F2845A3, with mixed in_inverse on back-to-back words.
REQ-037 STAGES=3, 10 back-to-back words, out_ready=1 -> first out_valid 3 cycles after first accept; 10 consecutive outputs in order; count=10.
REQ-038 Backpressure: out_ready=0 for 5 cycles with the pipe full -> in_ready=0, out_data stable. Then out_ready=1 -> all words drain in order with no loss or duplication.
REQ-039 Preload count to 0xFFFF with 65535 transfers, then one more transfer -> count=0x0000. clear=1 with a full pipe and in_valid=1 -> next cycle out_valid=0, count=0, input not accepted.
REQ-040 reset_n pulsed low between clock edges with the pipe full -> immediate out_valid=0, out_data=0, count=0; no output handshake.
